// File: rtl/fc_stream_loader_if.sv
// Stream-side and FC-top-side signals of the vector loader.
// The "slave" modport is the loader; "master" is the source and FC top it serves.
interface fc_stream_loader_if #(
   parameter int DATA_WIDTH = 16,
   parameter int IN_DIM     = 200
);
   logic                         s_valid;
   logic                         s_ready;
   logic signed [DATA_WIDTH-1:0] s_data;
   logic                         s_last;
   logic                         fc_start;
   logic signed [DATA_WIDTH-1:0] fc_in_vector [0:IN_DIM-1];
   logic                         fc_done;

   modport master (
      output s_valid, s_data, s_last, fc_done,
      input  s_ready, fc_start, fc_in_vector
   );

   modport slave (
      input  s_valid, s_data, s_last, fc_done,
      output s_ready, fc_start, fc_in_vector
   );
endinterface

// File: rtl/fc_stream_loader.sv
// Packs a valid/ready element stream into ping-pong IN_DIM vectors and launches the FC top,
// holding the active bank stable while the next vector fills the other bank.
module fc_stream_loader #(
   parameter int DATA_WIDTH = 16,
   parameter int IN_DIM     = 200,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   fc_stream_loader_if.slave    lp,
   output logic                 busy,
   output logic                 len_err,
   output logic [CNT_WIDTH-1:0] vec_count
);
   localparam int IDX_W = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_DIM - 1);

   typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

   state_t                       state;
   logic signed [DATA_WIDTH-1:0] bank [0:1][0:IN_DIM-1];
   logic [IDX_W-1:0]             wr_idx;
   logic                         fill_sel;
   logic                         active_sel;
   logic                         fill_full;
   logic                         handshake;
   logic                         last_slot;
   logic                         store;

   assign lp.s_ready = ~fill_full;
   assign handshake  = lp.s_valid & ~fill_full;
   assign last_slot  = (wr_idx == LAST_IDX);
   // An early s_last drops the beat along with the partial vector.
   assign store      = handshake & (last_slot | ~lp.s_last);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < IN_DIM; k++) begin
               bank[b][k] <= '0;
            end
         end
      end else if (store) begin
         bank[fill_sel][wr_idx] <= lp.s_data;
      end
   end

   always_comb begin
      for (int k = 0; k < IN_DIM; k++) begin
         lp.fc_in_vector[k] = bank[active_sel][k];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_idx      <= '0;
         fill_sel    <= 1'b0;
         active_sel  <= 1'b1;
         fill_full   <= 1'b0;
         state       <= IDLE;
         lp.fc_start <= 1'b0;
         busy        <= 1'b0;
         len_err     <= 1'b0;
         vec_count   <= '0;
      end else begin
         if (handshake) begin
            if (last_slot) begin
               fill_full <= 1'b1;
               wr_idx    <= '0;
               if (!lp.s_last) begin
                  len_err <= 1'b1;
               end
            end else if (lp.s_last) begin
               len_err <= 1'b1;
               wr_idx  <= '0;
            end else begin
               wr_idx <= wr_idx + 1'b1;
            end
         end

         lp.fc_start <= 1'b0;
         // The swap only happens with fill_full set, so it never races a fill-side handshake.
         case (state)
            IDLE: begin
               if (fill_full) begin
                  active_sel  <= fill_sel;
                  fill_sel    <= ~fill_sel;
                  fill_full   <= 1'b0;
                  lp.fc_start <= 1'b1;
                  busy        <= 1'b1;
                  state       <= START;
               end
            end
            START: begin
               state <= BUSY;
            end
            BUSY: begin
               if (lp.fc_done) begin
                  vec_count <= vec_count + 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
